// File: rtl/composite_sync_gen.sv
// Composite-video timing generator: pixel-rate divider, x/y/field counters,
// active-low composite sync with equalising and serrated broad pulses, and a
// registered active-video flag. Optional 2:1 interlace.
module composite_sync_gen #(
  parameter int CLK_DIV     = 5,
  parameter int H_TOTAL     = 640,
  parameter int H_ACTIVE    = 490,
  parameter int HSYNC_START = 528,
  parameter int HSYNC_W     = 47,
  parameter int EQ_W        = 23,
  parameter int SERR_W      = 47,
  parameter int V_TOTAL     = 309,
  parameter int V_ACTIVE    = 268,
  parameter int VS_HL       = 536,
  parameter int PRE_EQ      = 4,
  parameter int BROAD       = 5,
  parameter int POST_EQ     = 4,
  parameter int INTERLACE   = 0,
  localparam int XW = $clog2(H_TOTAL),
  localparam int YW = $clog2(V_TOTAL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_en,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic          field,
  output logic          active,
  output logic          sync_n,
  output logic          frame_start
);

  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Half-line index needs one bit more than 2*ypos+1; the extra bit keeps
  // (hv - VS_HL) wrapping far above the region lengths when hv < VS_HL.
  localparam int HW     = YW + 3;
  localparam int HALF   = H_TOTAL / 2;
  localparam int HS_OFF = HSYNC_START - HALF;

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          field_q, field_d;
  logic          active_q, active_d;
  logic          sync_n_q, sync_n_d;
  logic          frame_start_q, frame_start_d;

  logic          x_last, y_last, odd_field;
  logic          half, in_hs, in_eq, in_serr, s;
  logic [XW-1:0] xh;
  logic [HW-1:0] hv, off;

  // Pixel strobe: last divider phase, suppressed while reset is held so that
  // CLK_DIV=1 does not strobe during reset.
  assign pix_en    = (div_q == DW'(CLK_DIV - 1)) && !reset;
  assign odd_field = (INTERLACE != 0) && field_q;

  // Divider and x/y/field counters; frame_start marks the wrap to (0,0).
  always_comb begin
    div_d         = pix_en ? '0 : div_q + 1'b1;
    x_last        = (x_q == XW'(H_TOTAL - 1));
    y_last        = odd_field ? (y_q == YW'(V_TOTAL)) : (y_q == YW'(V_TOTAL - 1));
    x_d           = x_q;
    y_d           = y_q;
    field_d       = field_q;
    frame_start_d = pix_en && x_last && y_last;
    if (pix_en) begin
      x_d = x_last ? '0 : x_q + 1'b1;
      if (x_last) begin
        y_d = y_last ? '0 : y_q + 1'b1;
        if (y_last) field_d = (INTERLACE != 0) ? !field_q : 1'b0;
      end
    end
  end

  // Half-line slot decode and sync term; each slot is judged on its own.
  always_comb begin
    half    = ({1'b0, x_q} >= (XW+1)'(HALF));
    xh      = half ? x_q - XW'(HALF) : x_q;
    hv      = {2'b00, y_q, 1'b0} + HW'(half) + HW'(odd_field);
    off     = hv - HW'(VS_HL);
    // Unsigned window tests: (xh - lo) < width covers lo <= xh < lo+width.
    in_hs   = (xh - XW'(HS_OFF)) < XW'(HSYNC_W);
    in_eq   = (xh - XW'(HS_OFF)) < XW'(EQ_W);
    in_serr = (xh - XW'(HS_OFF - SERR_W)) < XW'(SERR_W);
    if (off < HW'(PRE_EQ))                      s = in_eq;
    else if (off < HW'(PRE_EQ + BROAD))         s = !in_serr;
    else if (off < HW'(PRE_EQ + BROAD + POST_EQ)) s = in_eq;
    else                                        s = half && in_hs;
  end

  // Registered video outputs from the current counter state.
  always_comb begin
    active_d = ({1'b0, x_q} < (XW+1)'(H_ACTIVE)) && ({1'b0, y_q} < (YW+1)'(V_ACTIVE));
    sync_n_d = active_d || !s;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      field_q       <= 1'b0;
      active_q      <= 1'b0;
      sync_n_q      <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      field_q       <= field_d;
      active_q      <= active_d;
      sync_n_q      <= sync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign xpos        = x_q;
  assign ypos        = y_q;
  assign field       = field_q;
  assign active      = active_q;
  assign sync_n      = sync_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_composite_sync_gen.sv
// Directed bench for composite_sync_gen: default timing on line 0, a tiny
// 16x8 raster at CLK_DIV=1, and an interlaced short-field raster (640 pixels,
// 20/21 lines, CLK_DIV=1) whose sync regions map onto the default geometry.
module tb_composite_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_s, rst_i;

  // Default parameter set
  logic       pix_en, field, active, sync_n, frame_start;
  logic [9:0] xpos;
  logic [8:0] ypos;
  // Small raster
  logic       pix_en_s, field_s, active_s, sync_n_s, frame_start_s;
  logic [3:0] xpos_s;
  logic [3:0] ypos_s;
  // Interlaced short-field raster
  logic       pix_en_i, field_i, active_i, sync_n_i, frame_start_i;
  logic [9:0] xpos_i;
  logic [4:0] ypos_i;

  int vectors = 0;
  int miscompares = 0;

  composite_sync_gen dut (
    .clk(clk), .reset(rst), .pix_en(pix_en), .xpos(xpos), .ypos(ypos),
    .field(field), .active(active), .sync_n(sync_n), .frame_start(frame_start)
  );

  composite_sync_gen #(
    .CLK_DIV(1), .H_TOTAL(16), .H_ACTIVE(10), .HSYNC_START(12), .HSYNC_W(2),
    .EQ_W(1), .SERR_W(2), .V_TOTAL(8), .V_ACTIVE(5), .VS_HL(10),
    .PRE_EQ(1), .BROAD(2), .POST_EQ(1), .INTERLACE(0)
  ) dut_s (
    .clk(clk), .reset(rst_s), .pix_en(pix_en_s), .xpos(xpos_s), .ypos(ypos_s),
    .field(field_s), .active(active_s), .sync_n(sync_n_s), .frame_start(frame_start_s)
  );

  composite_sync_gen #(
    .CLK_DIV(1), .H_TOTAL(640), .H_ACTIVE(490), .HSYNC_START(528), .HSYNC_W(47),
    .EQ_W(23), .SERR_W(47), .V_TOTAL(20), .V_ACTIVE(10), .VS_HL(20),
    .PRE_EQ(4), .BROAD(5), .POST_EQ(4), .INTERLACE(1)
  ) dut_i (
    .clk(clk), .reset(rst_i), .pix_en(pix_en_i), .xpos(xpos_i), .ypos(ypos_i),
    .field(field_i), .active(active_i), .sync_n(sync_n_i), .frame_start(frame_start_i)
  );

  // ---------------- clock helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed low-mask %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit x set where sync_n must be low; ranges with a negative start are unused.
  function automatic logic [639:0] mask(input int a0, input int a1, input int b0,
                                        input int b1, input int c0, input int c1);
    logic [639:0] m;
    m = '0;
    for (int i = 0; i < 640; i++) begin
      if ((a0 >= 0 && i >= a0 && i <= a1) || (b0 >= 0 && i >= b0 && i <= b1) ||
          (c0 >= 0 && i >= c0 && i <= c1))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  // Advance the interlaced raster until its counters show (x,y,f).
  task automatic seek_i(input int x, input int y, input int f, input string tag);
    int n;
    logic found;
    n = 0;
    found = (xpos_i == x) && (ypos_i == y) && (field_i == f);
    while (!found && n < 30000) begin
      tick();
      n++;
      found = (xpos_i == x) && (ypos_i == y) && (field_i == f);
    end
    chk(tag, found, 1);
  endtask

  // Record which pixels of line y in field f drive sync_n low.
  task automatic capture_i(input int y, input int f, input string tag,
                           output logic [639:0] lo);
    seek_i(0, y, f, tag);
    lo = '0;
    for (int i = 0; i < 640; i++) begin
      tick();
      lo[i] = (sync_n_i === 1'b0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [639:0] ln;
    int prev_x, lo_cnt, act_cnt, first_lo_x, last_lo_x, act_fall_x, y1_tick;
    int pe_low, fs_cnt, fs1, fs2, fld_bad, xmax, ymax, fs_after;

    rst = 1'b1; rst_s = 1'b1; rst_i = 1'b1;
    repeat (3) tick();

    // Reset values, default instance
    chk("rst_pix_en", pix_en, 0);
    chk("rst_xpos", xpos, 0);
    chk("rst_ypos", ypos, 0);
    chk("rst_field", field, 0);
    chk("rst_active", active, 0);
    chk("rst_sync_n", sync_n, 1);
    chk("rst_frame_start", frame_start, 0);

    // First pixel strobe arrives on the 5th clk after release
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("pix_en_clk%0d", k), pix_en, (k == 4) ? 1 : 0);
    end
    chk("xpos_before_first_step", xpos, 0);
    tick();
    chk("xpos_after_first_step", xpos, 1);
    chk("pix_en_after_first_step", pix_en, 0);

    // One full line period of registered outputs (3200 clks)
    prev_x = xpos; lo_cnt = 0; act_cnt = 0;
    first_lo_x = -1; last_lo_x = -1; act_fall_x = -1; y1_tick = -1;
    for (int t = 6; t <= 3205; t++) begin
      tick();
      if (sync_n === 1'b0) begin
        lo_cnt++;
        if (first_lo_x < 0) first_lo_x = prev_x;
        last_lo_x = prev_x;
      end
      if (active === 1'b1) act_cnt++;
      else if (act_fall_x < 0) act_fall_x = prev_x;
      if (ypos == 1 && y1_tick < 0) y1_tick = t;
      prev_x = xpos;
    end
    chk("line0_sync_clks", lo_cnt, 235);
    chk("line0_sync_first_x", first_lo_x, 528);
    chk("line0_sync_last_x", last_lo_x, 574);
    chk("line0_active_clks", act_cnt, 2450);
    chk("line0_active_end_x", act_fall_x, 490);
    chk("line_length_clks", y1_tick, 3200);
    chk("field_non_interlaced", field, 0);

    // Small raster, CLK_DIV=1: strobe always high, 128-clk frames
    rst_s = 1'b0;
    #1;
    chk("small_pix_en_release", pix_en_s, 1);
    pe_low = 0; fs_cnt = 0; fs1 = -1; fs2 = -1; fld_bad = 0; xmax = 0; ymax = 0;
    for (int t = 1; t <= 300; t++) begin
      tick();
      if (pix_en_s !== 1'b1) pe_low++;
      if (frame_start_s === 1'b1) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = t;
        else if (fs2 < 0) fs2 = t;
      end
      if (field_s !== 1'b0) fld_bad++;
      if (int'(xpos_s) > xmax) xmax = int'(xpos_s);
      if (int'(ypos_s) > ymax) ymax = int'(ypos_s);
    end
    chk("small_pix_en_low_clks", pe_low, 0);
    chk("small_frame_start_count", fs_cnt, 2);
    chk("small_frame_start_first", fs1, 128);
    chk("small_frame_start_second", fs2, 256);
    chk("small_field_stuck_0", fld_bad, 0);
    chk("small_xpos_max", xmax, 15);
    chk("small_ypos_max", ymax, 7);

    // Interlaced short-field raster: sync shapes per line
    rst_i = 1'b0;
    capture_i(0, 0, "seek_f0_l0", ln);
    chk_line("f0_line0_normal", ln, mask(528, 574, -1, -1, -1, -1));
    capture_i(9, 0, "seek_f0_l9", ln);
    chk_line("f0_line9_normal", ln, mask(528, 574, -1, -1, -1, -1));
    capture_i(10, 0, "seek_f0_l10", ln);
    chk_line("f0_line10_eq", ln, mask(208, 230, 528, 550, -1, -1));
    capture_i(12, 0, "seek_f0_l12", ln);
    chk_line("f0_line12_broad", ln, mask(0, 160, 208, 480, 528, 639));
    capture_i(14, 0, "seek_f0_l14", ln);
    chk_line("f0_line14_broad_then_eq", ln, mask(0, 160, 208, 319, 528, 550));
    capture_i(17, 0, "seek_f0_l17", ln);
    chk_line("f0_line17_normal", ln, mask(528, 574, -1, -1, -1, -1));
    capture_i(9, 1, "seek_f1_l9", ln);
    chk_line("f1_line9_eq_half_early", ln, mask(528, 550, -1, -1, -1, -1));
    capture_i(10, 1, "seek_f1_l10", ln);
    chk_line("f1_line10_eq", ln, mask(208, 230, 528, 550, -1, -1));
    capture_i(15, 1, "seek_f1_l15", ln);
    chk_line("f1_line15_post_eq", ln, mask(208, 230, 528, 550, -1, -1));
    capture_i(20, 1, "seek_f1_l20_extra_line", ln);
    chk_line("f1_line20_normal", ln, mask(528, 574, -1, -1, -1, -1));

    // After the extra line the raster returns to field 0 with a frame pulse
    seek_i(0, 0, 0, "seek_wrap_to_f0");
    chk("wrap_frame_start", frame_start_i, 1);
    chk("wrap_ypos", ypos_i, 0);

    // Reset in the middle of a broad pulse of field 1
    seek_i(100, 12, 1, "seek_f1_l12_x100");
    chk("pre_reset_sync_low", sync_n_i, 0);
    rst_i = 1'b1;
    tick();
    chk("midreset_xpos", xpos_i, 0);
    chk("midreset_ypos", ypos_i, 0);
    chk("midreset_field", field_i, 0);
    chk("midreset_sync_n", sync_n_i, 1);
    chk("midreset_active", active_i, 0);
    chk("midreset_frame_start", frame_start_i, 0);
    rst_i = 1'b0;
    fs_after = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (frame_start_i === 1'b1) fs_after++;
    end
    chk("post_reset_xpos", xpos_i, 5);
    chk("post_reset_no_frame_start", fs_after, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
